// File: rtl/arp_requester.sv
// -----------------------------------------------------------------------------
// arp_requester
// ARP initiator. On a query it broadcasts an ARP request for query_ip on the
// shared Ethernet tx stream, watches the shared rx stream for the matching
// reply and returns the resolved MAC. Each attempt waits TIMEOUT cycles, with
// up to RETRIES resends. A single {ip, mac} entry caches the last resolution.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   mac, ip           own hardware / protocol address (sha / spa of requests)
//   query, query_ip   1-cycle resolve request and the IP to resolve
//   flush             invalidate the cache entry (only acted on when idle)
//   busy              a request is in flight
//   done, fail        1-cycle result pulses; resolved_mac valid with done
//   resolved_mac      last resolved MAC, held until the next accepted query
//   rx_*              incoming frame stream (header strobe, payload, end)
//   tx_go             Ethernet transmitter grant
//   tx_*              outgoing payload stream plus frame addressing/ethertype
// -----------------------------------------------------------------------------
module arp_requester #(
  parameter int HEADLEN = 28,
  parameter int TIMEOUT = 1250000,
  parameter int RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] mac,
  input  logic [31:0] ip,
  input  logic        query,
  input  logic [31:0] query_ip,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [47:0] resolved_mac,
  input  logic        rx_newframehead,
  input  logic [15:0] rx_ethertype,
  input  logic        rx_dven,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  input  logic        rx_frameend,
  input  logic        tx_go,
  output logic        tx_dven,
  output logic [7:0]  tx_data,
  output logic [47:0] tx_smac,
  output logic [47:0] tx_dmac,
  output logic [15:0] tx_ethertype
);

  localparam int PW = HEADLEN * 8;        // full ARP payload width
  localparam int RW = (HEADLEN - 6) * 8;  // oper..tpa, the fields a reply is judged on
  localparam int TW = $clog2(TIMEOUT);
  localparam int AW = $clog2(RETRIES + 2);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] RETRY_MAX = AW'(RETRIES);
  localparam logic [5:0]    HL        = 6'(HEADLEN);
  localparam logic [15:0]   ETH_ARP   = 16'h0806;

  typedef enum logic [1:0] {S_IDLE, S_WAITGO, S_SEND, S_WAITREPLY} state_t;

  state_t         r_state, w_state_nxt;
  logic [31:0]    r_target;
  logic           r_cache_valid;
  logic [31:0]    r_cache_ip;
  logic [47:0]    r_cache_mac;
  logic [AW-1:0]  r_attempt;
  logic [TW-1:0]  r_timer;
  logic [5:0]     r_byte;
  logic [PW-1:0]  r_tx_shift;
  logic           r_tx_dven;
  logic [7:0]     r_tx_data;
  logic           r_done;
  logic           r_fail;
  logic [47:0]    r_resolved_mac;
  logic           r_rx_arm;
  logic [5:0]     r_rx_cnt;
  logic           r_rx_bad;
  logic [RW-1:0]  r_rx_shift;

  logic           w_hit;
  logic           w_rx_ok;
  logic           w_timeout;
  logic           w_can_retry;
  logic [PW-1:0]  w_req_vec;
  logic [15:0]    w_rx_oper;
  logic [47:0]    w_rx_sha;
  logic [31:0]    w_rx_spa;
  logic [47:0]    w_rx_tha;
  logic [31:0]    w_rx_tpa;

  // Request payload, most significant byte transmitted first.
  assign w_req_vec = PW'({16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0001,
                          mac, ip, 48'h0, r_target});

  // The rx shift register only keeps the last RW bits, so after a full
  // 28-byte capture the fixed header bytes have already fallen off the top.
  assign w_rx_oper = r_rx_shift[RW-1   -: 16];
  assign w_rx_sha  = r_rx_shift[RW-17  -: 48];
  assign w_rx_spa  = r_rx_shift[RW-65  -: 32];
  assign w_rx_tha  = r_rx_shift[RW-97  -: 48];
  assign w_rx_tpa  = r_rx_shift[31:0];

  // Flush wins over a same-cycle query, so it forces a miss.
  assign w_hit       = r_cache_valid && !flush && (r_cache_ip == query_ip);
  assign w_timeout   = (r_timer == '0);
  assign w_can_retry = (r_attempt < RETRY_MAX);
  assign w_rx_ok     = r_rx_arm && rx_frameend && (r_rx_cnt == HL) && !r_rx_bad &&
                       (w_rx_oper == 16'h0002) && (w_rx_spa == r_target) &&
                       (w_rx_tpa == ip) && (w_rx_tha == mac);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the same pre-edge values; blocking here would make
  // results depend on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment up front means every path assigns
  // w_state_nxt, so no latch is inferred when a branch leaves it alone.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (query && !w_hit) w_state_nxt = S_WAITGO;
      S_WAITGO:    if (tx_go) w_state_nxt = S_SEND;
      S_SEND:      if (r_byte == HL) w_state_nxt = S_WAITREPLY;
      S_WAITREPLY: begin
        // A reply that lands on the expiry cycle still resolves the query.
        if (w_rx_ok)        w_state_nxt = S_IDLE;
        else if (w_timeout) w_state_nxt = w_can_retry ? S_WAITGO : S_IDLE;
      end
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request datapath: target, cache, attempt/timeout counters, tx stream
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target       <= '0;
      r_cache_valid  <= 1'b0;
      r_cache_ip     <= '0;
      r_cache_mac    <= '0;
      r_attempt      <= '0;
      r_timer        <= '0;
      r_byte         <= '0;
      r_tx_shift     <= '0;
      r_tx_dven      <= 1'b0;
      r_tx_data      <= '0;
      r_done         <= 1'b0;
      r_fail         <= 1'b0;
      r_resolved_mac <= '0;
    end else begin
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_tx_dven <= 1'b0;
      r_tx_data <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (flush) r_cache_valid <= 1'b0;
          if (query) begin
            r_target <= query_ip;
            if (w_hit) begin
              r_done         <= 1'b1;
              r_resolved_mac <= r_cache_mac;
            end else begin
              r_attempt <= '0;
            end
          end
        end
        S_WAITGO: begin
          if (tx_go) begin
            r_tx_shift <= w_req_vec;
            r_byte     <= '0;
          end
        end
        S_SEND: begin
          // r_byte==0 is a one-cycle lead-in; bytes go out on counts 1..HEADLEN.
          r_byte <= r_byte + 6'd1;
          if (r_byte != '0) begin
            r_tx_dven  <= 1'b1;
            r_tx_data  <= r_tx_shift[PW-1 -: 8];
            r_tx_shift <= r_tx_shift << 8;
          end
          if (r_byte == HL) r_timer <= TO_LOAD;
        end
        S_WAITREPLY: begin
          if (w_rx_ok) begin
            r_done         <= 1'b1;
            r_resolved_mac <= w_rx_sha;
            r_cache_valid  <= 1'b1;
            r_cache_ip     <= r_target;
            r_cache_mac    <= w_rx_sha;
          end else if (w_timeout) begin
            if (w_can_retry) r_attempt <= r_attempt + AW'(1);
            else             r_fail    <= 1'b1;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Rx parser: always listening, judged at rx_frameend
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_arm   <= 1'b0;
      r_rx_cnt   <= '0;
      r_rx_bad   <= 1'b0;
      r_rx_shift <= '0;
    end else if (rx_newframehead) begin
      // A new header always restarts capture, discarding any partial frame.
      r_rx_arm <= (rx_ethertype == ETH_ARP);
      r_rx_cnt <= '0;
      r_rx_bad <= 1'b0;
    end else if (rx_frameend) begin
      r_rx_arm <= 1'b0;
    end else if (r_rx_arm) begin
      if (rx_dven && (r_rx_cnt < HL)) begin
        r_rx_shift <= {r_rx_shift[RW-9:0], rx_data};
        r_rx_cnt   <= r_rx_cnt + 6'd1;
      end
      if (rx_err) r_rx_bad <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign fail         = r_fail;
  assign resolved_mac = r_resolved_mac;
  assign tx_dven      = r_tx_dven;
  assign tx_data      = r_tx_data;
  assign tx_smac      = r_tx_dven ? mac : 48'h0;
  assign tx_dmac      = r_tx_dven ? 48'hffff_ffff_ffff : 48'h0;
  assign tx_ethertype = r_tx_dven ? ETH_ARP : 16'h0;

endmodule
